// File: rtl/fc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fc_seq_ctrl
//
// Sequencing controller for the fully-connected layer datapath. It loads an
// N-word input vector into vector memory, then walks the M x N weight matrix
// row by row. Accumulator enables are aligned to the read latency RD_LAT of
// the vector memory and weight ROM. Each row result is offered to the
// downstream consumer through a valid/ready handshake.
//
// Handshake semantics (both ports): a transfer happens in a cycle where valid
// and ready are both 1 at the rising edge of clk. The input side never stalls
// on its own: input_ready is 1 for the whole LOAD state. output_valid is
// held at 1, with row_idx and addr_w stable, until output_ready is sampled
// high.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-low reset
//   input_valid   input word valid
//   input_ready   controller accepts an input word (LOAD state only)
//   output_ready  downstream accepts a row result
//   output_valid  datapath output holds a finished row result
//   addr_x        vector memory address (load index in LOAD, column otherwise)
//   wr_en_x       vector memory write enable
//   addr_w        weight ROM address, r*N + c
//   en_acc        accumulate enable, issue flag delayed by RD_LAT cycles
//   clear_acc     accumulator clear, first issue cycle of each row
//   busy          high in every state except LOAD
//   row_idx       current row r
//   state_dbg     encoded FSM state (0 LOAD, 1 ISSUE, 2 DRAIN, 3 OUT)
// ----------------------------------------------------------------------------
module fc_seq_ctrl #(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int RD_LAT    = 1,
    parameter int LOGSIZE_M = $clog2(M * N),
    parameter int LOGSIZE_N = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic                   output_ready,
    output logic                   output_valid,
    output logic [LOGSIZE_N-1:0]   addr_x,
    output logic                   wr_en_x,
    output logic [LOGSIZE_M-1:0]   addr_w,
    output logic                   en_acc,
    output logic                   clear_acc,
    output logic                   busy,
    output logic [$clog2(M)-1:0]   row_idx,
    output logic [1:0]             state_dbg
);

    localparam int LOGSIZE_R = $clog2(M);

    localparam logic [LOGSIZE_N-1:0] LAST_C = LOGSIZE_N'(N - 1);
    localparam logic [LOGSIZE_R-1:0] LAST_R = LOGSIZE_R'(M - 1);
    localparam logic [2:0]           LAST_D = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 state;
    logic [LOGSIZE_N-1:0]   k;      // load count
    logic [LOGSIZE_N-1:0]   c;      // column
    logic [LOGSIZE_R-1:0]   r;      // row
    logic [2:0]             d;      // drain cycle count
    logic [RD_LAT-1:0]      vld;    // issued-read delay line

    logic                   accept;

    assign accept = input_valid & input_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD;
            k     <= '0;
            c     <= '0;
            r     <= '0;
            d     <= '0;
            vld   <= '0;
        end else begin
            // Every issued read travels RD_LAT stages before its data is
            // valid at the accumulator; the tap at RD_LAT-1 drives en_acc.
            vld[0] <= (state == S_ISSUE);
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end

            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (k == LAST_C) begin
                            k     <= '0;
                            r     <= '0;
                            c     <= '0;
                            state <= S_ISSUE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (c == LAST_C) begin
                        c     <= '0;
                        d     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Wait out the read latency so the last product of the
                    // row is accumulated before the result is offered.
                    if (d == LAST_D) begin
                        d     <= '0;
                        state <= S_OUT;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                S_OUT: begin
                    if (output_ready) begin
                        if (r == LAST_R) begin
                            r     <= '0;
                            state <= S_LOAD;
                        end else begin
                            r     <= r + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Outputs decode straight from the registered state and counters; only
    // the input handshake depends on live inputs (reset and input_valid).
    assign input_ready  = reset && (state == S_LOAD);
    assign wr_en_x      = accept;
    assign addr_x       = (state == S_LOAD) ? k : c;
    assign addr_w       = LOGSIZE_M'(32'(r) * 32'(N) + 32'(c));
    assign en_acc       = vld[RD_LAT-1];
    assign clear_acc    = (state == S_ISSUE) && (c == '0);
    assign output_valid = (state == S_OUT);
    assign busy         = (state != S_LOAD);
    assign row_idx      = r;
    assign state_dbg    = state;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fc_seq_ctrl
//
// Two controller instances share one clock:
//   u_dut  M=N=4, RD_LAT=1, checked cycle by cycle from a vector table and a
//          full-vector sequence.
//   u_sys  M=N=4, RD_LAT=2, wrapped in a behavioural fc datapath (vector
//          memory, weight ROM, both with a 2-cycle read pipe, accumulator);
//          row results are checked against hand-computed dot products.
// ----------------------------------------------------------------------------
module tb_fc_seq_ctrl;

    localparam int M = 4;
    localparam int N = 4;
    localparam int D = -1;  // don't-care marker in the vector table

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT (RD_LAT = 1)
    // ------------------------------------------------------------------
    logic       reset, input_valid, output_ready;
    logic       input_ready, output_valid, wr_en_x, en_acc, clear_acc, busy;
    logic [1:0] addr_x, row_idx, state_dbg;
    logic [3:0] addr_w;

    fc_seq_ctrl #(.M(M), .N(N), .RD_LAT(1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_ready (output_ready),
        .output_valid (output_valid),
        .addr_x       (addr_x),
        .wr_en_x      (wr_en_x),
        .addr_w       (addr_w),
        .en_acc       (en_acc),
        .clear_acc    (clear_acc),
        .busy         (busy),
        .row_idx      (row_idx),
        .state_dbg    (state_dbg)
    );

    // ------------------------------------------------------------------
    // System instance (RD_LAT = 2) with behavioural datapath
    // ------------------------------------------------------------------
    logic       s_reset, s_iv, s_or;
    logic       s_ir, s_ov, s_wr, s_en, s_clr, s_busy;
    logic [1:0] s_ax, s_row, s_state;
    logic [3:0] s_aw;
    int         s_din;

    fc_seq_ctrl #(.M(M), .N(N), .RD_LAT(2)) u_sys (
        .clk          (clk),
        .reset        (s_reset),
        .input_valid  (s_iv),
        .input_ready  (s_ir),
        .output_ready (s_or),
        .output_valid (s_ov),
        .addr_x       (s_ax),
        .wr_en_x      (s_wr),
        .addr_w       (s_aw),
        .en_acc       (s_en),
        .clear_acc    (s_clr),
        .busy         (s_busy),
        .row_idx      (s_row),
        .state_dbg    (s_state)
    );

    int wrom [16] = '{-110, 69, -64, 76,
                      -39, 103, 105, 44,
                      -34, -73, -53, 68,
                      -5, 116, 23, -78};
    int xmem [4]  = '{0, 0, 0, 0};
    int x_p  [2]  = '{0, 0};
    int w_p  [2]  = '{0, 0};
    int acc       = 0;

    always @(posedge clk) begin
        if (s_wr) xmem[s_ax] <= s_din;
        x_p[0] <= xmem[s_ax];
        w_p[0] <= wrom[s_aw];
        x_p[1] <= x_p[0];
        w_p[1] <= w_p[0];
        if (s_clr)     acc <= 0;
        else if (s_en) acc <= acc + x_p[1] * w_p[1];
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), exp);
        end
    endtask

    task automatic tchk(input string name, input logic [31:0] act, input int exp);
        if (exp != D) chk(name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no completion within cycle budget", name);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic rst;
        logic iv;
        logic orr;
        int   ir, wr, ax, bz, clr, en, ov, aw, row;
    } vec_t;

    vec_t tbl [30];

    // ------------------------------------------------------------------
    // System driver tasks
    // ------------------------------------------------------------------
    task automatic load_sys(input int xv [4], input string tag);
        int k = 0;
        for (int cyc = 0; cyc < 20 && k < N; cyc++) begin
            @(negedge clk);
            s_iv  = 1'b1;
            s_din = xv[k];
            #1;
            if (s_wr) k++;
        end
        if (k < N) fail_timeout({tag, " load"});
    endtask

    task automatic drain_sys(input int ev [4], input string tag);
        int   hs = 0;
        int   t0 = 0;
        logic prev_ov = 1'b0;
        foreach (ev[i]) exp_q.push_back(ev[i]);
        for (int cyc = 0; cyc < 200 && hs < M; cyc++) begin
            @(negedge clk);
            s_iv = 1'b0;
            s_or = 1'b1;
            #1;
            if (s_clr) t0 = cyc;
            if (s_ov && !prev_ov) chk({tag, " ov_rise_delay"}, cyc - t0, N + 2);
            if (s_ov && s_or) begin
                chk({tag, " row_result"}, acc, exp_q.pop_front());
                hs++;
            end
            prev_ov = s_ov;
        end
        if (hs < M) begin
            fail_timeout({tag, " results"});
            exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int x_a [4] = '{1, 2, 3, 4};
        int e_a [4] = '{140, 658, -67, -16};
        int x_b [4] = '{4, 3, 2, 1};
        int e_b [4] = '{-285, 407, -393, 296};

        reset        = 1'b0;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        s_reset      = 1'b0;
        s_iv         = 1'b0;
        s_or         = 1'b1;
        s_din        = 0;

        //            rst iv or   ir wr ax bz clr en ov aw row
        tbl[0]  = '{1'b0,1'b1,1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0,1'b1,1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0,1'b1,1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1,1'b0,1'b1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b1,1'b1,1'b0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1'b1,1'b0,1'b0, 1, 0, 1, 0, 0, 0, 0, D, 0};
        tbl[6]  = '{1'b1,1'b1,1'b0, 1, 1, 1, 0, 0, 0, 0, D, 0};
        tbl[7]  = '{1'b1,1'b1,1'b0, 1, 1, 2, 0, 0, 0, 0, D, 0};
        tbl[8]  = '{1'b1,1'b0,1'b0, 1, 0, 3, 0, 0, 0, 0, D, 0};
        tbl[9]  = '{1'b1,1'b1,1'b1, 1, 1, 3, 0, 0, 0, 0, D, 0};
        tbl[10] = '{1'b1,1'b1,1'b1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[11] = '{1'b1,1'b1,1'b1, 0, 0, 1, 1, 0, 1, 0, 1, 0};
        tbl[12] = '{1'b1,1'b0,1'b1, 0, 0, 2, 1, 0, 1, 0, 2, 0};
        tbl[13] = '{1'b1,1'b0,1'b1, 0, 0, 3, 1, 0, 1, 0, 3, 0};
        tbl[14] = '{1'b1,1'b0,1'b1, 0, 0, D, 1, 0, 1, 0, D, 0};
        tbl[15] = '{1'b1,1'b0,1'b1, 0, 0, D, 1, 0, 0, 1, D, 0};
        tbl[16] = '{1'b1,1'b0,1'b0, 0, 0, 0, 1, 1, 0, 0, 4, 1};
        tbl[17] = '{1'b1,1'b0,1'b0, 0, 0, 1, 1, 0, 1, 0, 5, 1};
        tbl[18] = '{1'b1,1'b0,1'b0, 0, 0, 2, 1, 0, 1, 0, 6, 1};
        tbl[19] = '{1'b1,1'b0,1'b0, 0, 0, 3, 1, 0, 1, 0, 7, 1};
        tbl[20] = '{1'b1,1'b0,1'b0, 0, 0, D, 1, 0, 1, 0, D, 1};
        tbl[21] = '{1'b1,1'b1,1'b0, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[22] = '{1'b1,1'b1,1'b0, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[23] = '{1'b1,1'b1,1'b0, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[24] = '{1'b1,1'b1,1'b0, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[25] = '{1'b1,1'b1,1'b0, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[26] = '{1'b1,1'b0,1'b1, 0, 0, D, 1, 0, 0, 1, 4, 1};
        tbl[27] = '{1'b1,1'b0,1'b1, 0, 0, 0, 1, 1, 0, 0, 8, 2};
        tbl[28] = '{1'b0,1'b0,1'b1, 0, 0, 1, 1, 0, 1, 0, 9, 2};
        tbl[29] = '{1'b1,1'b0,1'b1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        // Table: reset, gapped load, rows 0-1 with backpressure, reset mid-row 2
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            reset        = tbl[i].rst;
            input_valid  = tbl[i].iv;
            output_ready = tbl[i].orr;
            #1;
            tchk($sformatf("v%0d input_ready", i),  input_ready,  tbl[i].ir);
            tchk($sformatf("v%0d wr_en_x", i),      wr_en_x,      tbl[i].wr);
            tchk($sformatf("v%0d addr_x", i),       addr_x,       tbl[i].ax);
            tchk($sformatf("v%0d busy", i),         busy,         tbl[i].bz);
            tchk($sformatf("v%0d clear_acc", i),    clear_acc,    tbl[i].clr);
            tchk($sformatf("v%0d en_acc", i),       en_acc,       tbl[i].en);
            tchk($sformatf("v%0d output_valid", i), output_valid, tbl[i].ov);
            tchk($sformatf("v%0d addr_w", i),       addr_w,       tbl[i].aw);
            tchk($sformatf("v%0d row_idx", i),      row_idx,      tbl[i].row);
        end

        // Full vector on u_dut with output_ready held high
        begin
            int   n = -1;
            int   acc_cnt = 0, clr_cnt = 0, en_cnt = 0, hs = 0, widx = 0;
            logic prev_issue = 1'b0;
            bit   done = 1'b0;
            for (int cyc = 0; cyc < 100 && !done; cyc++) begin
                @(negedge clk);
                input_valid  = (acc_cnt < N);
                output_ready = 1'b1;
                #1;
                if (acc_cnt == N && input_ready) begin
                    chk("full_vector_cycles", n + 1, N + M * (N + 1 + 1));
                    chk("full_vector_row_idx", row_idx, 0);
                    done = 1'b1;
                end else begin
                    if (n >= 0) n++;
                    else if (wr_en_x) n = 0;
                    if (wr_en_x) begin
                        chk("full_vector_addr_x", addr_x, acc_cnt);
                        acc_cnt++;
                    end
                    if (state_dbg == 2'd1) begin
                        chk("full_vector_addr_w", addr_w, widx);
                        widx++;
                    end
                    if (n > 0) chk("full_vector_en_lag", en_acc, prev_issue);
                    clr_cnt += int'(clear_acc);
                    en_cnt  += int'(en_acc);
                    hs      += int'(output_valid);
                    prev_issue = (state_dbg == 2'd1);
                end
            end
            if (!done) fail_timeout("full_vector");
            chk("full_vector_clear_count", clr_cnt, M);
            chk("full_vector_en_count", en_cnt, M * N);
            chk("full_vector_outputs", hs, M);
            chk("full_vector_issues", widx, M * N);
        end

        // System instance: results with RD_LAT = 2
        @(negedge clk);
        s_reset = 1'b1;
        #1;
        chk("sys input_ready after reset", s_ir, 1);
        load_sys(x_a, "sys_a");
        drain_sys(e_a, "sys_a");

        // System instance: reset during row 2, column 1
        load_sys(x_a, "sys_mr");
        begin
            bit hit = 1'b0;
            for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
                @(negedge clk);
                s_iv = 1'b0;
                #1;
                if (s_row == 2'd2 && s_clr) hit = 1'b1;
            end
            if (!hit) fail_timeout("sys_mr row2");
        end
        @(negedge clk);
        s_reset = 1'b0;
        #1;
        chk("sys_mr addr_w at c1", s_aw, 9);
        @(negedge clk);
        s_reset = 1'b1;
        #1;
        chk("sys_mr en_acc", s_en, 0);
        chk("sys_mr clear_acc", s_clr, 0);
        chk("sys_mr output_valid", s_ov, 0);
        chk("sys_mr busy", s_busy, 0);
        chk("sys_mr state", s_state, 0);
        @(negedge clk);
        #1;
        chk("sys_mr en_acc flushed", s_en, 0);
        load_sys(x_b, "sys_b");
        drain_sys(e_b, "sys_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Sequencing controller for the fully-connected layer datapath (vector memory, weight ROM, accumulator datapath). It accepts an N-word input vector through a valid/ready handshake and writes it into vector memory. It then walks the M×N weight matrix row by row, aligning accumulator enables to a parameterized memory/ROM read latency, and presents each of the M row results through a valid/ready output handshake. It replaces the fixed-latency control FSM when the weight store is pipelined.

## Interface
- M, 4, number of output rows
- N, 4, number of input columns (vector length)
- RD_LAT, 1, read latency in cycles of vector memory and weight ROM; legal range 1..4
- LOGSIZE_M, $clog2(M*N), weight address width
- LOGSIZE_N, $clog2(N), vector address width

- clk  in  1  clock, all logic on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- input_valid  in  1  input word valid
- input_ready  out  1  controller accepts an input word
- output_ready  in  1  downstream accepts a result
- output_valid  out  1  datapath output_data holds a row result
- addr_x  out  LOGSIZE_N  vector memory address
- wr_en_x  out  1  vector memory write enable
- addr_w  out  LOGSIZE_M  weight ROM address
- en_acc  out  1  accumulate enable to the datapath
- clear_acc  out  1  accumulator clear to the datapath
- busy  out  1  high in any state except LOAD
- row_idx  out  $clog2(M)  current row r

## Operation
- States: LOAD, ISSUE, DRAIN, OUT. Counters: load count k (0..N-1), row r (0..M-1), column c (0..N-1). Delay line vld[RD_LAT] tracks issued reads.
- LOAD
  - input_ready = 1 (forced 0 while reset low).
  - wr_en_x = input_valid & input_ready; addr_x = k.
  - Each accepted word increments k. On the Nth accept: k←0, r←0, c←0, go to ISSUE.
- ISSUE
  - addr_x = c; addr_w = r*N + c; vld input = 1.
  - clear_acc = 1 only when c==0.
  - c increments every cycle. When c==N-1: c←0, go to DRAIN.
- DRAIN: vld input = 0; stays exactly RD_LAT cycles, then goes to OUT.
- en_acc = vld[RD_LAT-1], i.e. the issue flag delayed by RD_LAT cycles. It goes high for exactly N cycles per row.
- OUT
  - output_valid = 1, held stable until output_ready.
  - On handshake with r==M-1: r←0, go to LOAD.
  - On handshake otherwise: r←r+1, go to ISSUE.
- Ignored inputs: input_valid outside LOAD, and output_ready outside OUT.
- Address outputs in states that do not use them: value is don't-care, but the enables (wr_en_x, en_acc, clear_acc) must be 0.
- addr_w arithmetic is unsigned and never exceeds M*N-1. No wrap occurs within a vector.

## Timing
- Reset (reset low at a rising edge):
  - State becomes LOAD; all counters and vld cleared.
  - Next cycle: output_valid=0, en_acc=0, clear_acc=0, wr_en_x=0, busy=0, row_idx=0, addr_x=0, addr_w=0.
  - input_ready=0 while reset is low.
- Reset mid-operation: aborts immediately and discards any partial vector or row. No en_acc may appear from the flushed delay line.
- Per row, relative to issue cycle t0 (c=0):
  - clear_acc at t0.
  - en_acc at t0+RD_LAT .. t0+RD_LAT+N-1.
  - output_valid first at t0+N+RD_LAT.
- With output_ready held 1, a full vector takes N + M*(N+RD_LAT+1) cycles after the first accept.
- Backpressure in OUT freezes all counters and keeps every enable at 0.
- input_ready falls in the cycle after the Nth accept. It rises in the cycle after the last output handshake.

## Test plan
- Reset: hold reset low 3 cycles with input_valid=1 and output_ready=1 → input_ready=0, wr_en_x=0, en_acc=0, output_valid=0 throughout. After release, input_ready=1 on the next cycle.
- Load with gaps (M=N=4, RD_LAT=1): input_valid pattern 1,0,1,1,0,1 → wr_en_x only on valid cycles, addr_x=0,1,2,3. busy=1 and input_ready=0 the cycle after the 4th accept.
- Row sequencing (M=N=4, RD_LAT=1, output_ready=1):
  - addr_w runs 0..15 in order, with one output cycle between rows.
  - clear_acc once per row at c=0; en_acc lags issue by 1, 4 pulses per row.
  - output_valid 2 cycles after the last issue of each row.
- Backpressure: output_ready=0 for 5 cycles while row_idx=1 → output_valid held at 1, addr_w frozen, en_acc=0, row_idx stays 1. Row 2 issue starts the cycle after the handshake.
- System, RD_LAT=2 with the fc datapath and weights -110,69,-64,76 / -39,103,105,44 / -34,-73,-53,68 / -5,116,23,-78:
  - Input x=1,2,3,4 → outputs 140, 658, -67, -16 in row order.
  - Each output_valid rises 3 cycles after the row's last issue.
- Reset mid-ISSUE (row 2, c=1): drive reset low for 1 cycle → next cycle en_acc=0, clear_acc=0, output_valid=0, state LOAD. A following full vector produces correct results.
